// File: rtl/frame_buf_reader.sv
// Raster read-out engine: sweeps one frame from the frame-buffer memory and
// streams it out through a 3-entry FIFO as valid/ready pixels with sof/eol tags.
module frame_buf_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int H_PIXELS   = 4,
  parameter int V_LINES    = 2,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  pix_sof,
  output logic                  pix_eol
);

  localparam int CW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int LW = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam logic [ADDR_WIDTH-1:0] BASE_A   = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [CW-1:0]         COL_LAST = CW'(H_PIXELS - 1);
  localparam logic [LW-1:0]         LINE_LAST = LW'(V_LINES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           col_q, col_d;
  logic [LW-1:0]           line_q, line_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    in_flight_q, in_flight_d;
  logic                    sof_fl_q, sof_fl_d;
  logic                    eol_fl_q, eol_fl_d;
  logic [1:0]              count_q, count_d;
  logic [1:0]              rd_ptr_q, rd_ptr_d;
  logic [1:0]              wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0]   fifo_data_q [3];
  logic [DATA_WIDTH-1:0]   fifo_data_d [3];
  logic [2:0]              fifo_sof_q, fifo_sof_d;
  logic [2:0]              fifo_eol_q, fifo_eol_d;

  logic issue, push, pop, last_pix;

  assign busy        = (state_q != IDLE);
  assign frame_done  = (state_q == DONE);
  assign mem_rd_en   = issue;
  assign mem_rd_addr = addr_q;
  assign pix_valid   = (count_q != 2'd0);
  assign pix_data    = fifo_data_q[rd_ptr_q];
  assign pix_sof     = fifo_sof_q[rd_ptr_q];
  assign pix_eol     = fifo_eol_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    line_d      = line_q;
    addr_d      = addr_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    fifo_data_d = fifo_data_q;
    fifo_sof_d  = fifo_sof_q;
    fifo_eol_d  = fifo_eol_q;

    // Issue decision uses only registered occupancy, never pix_ready.
    issue    = (state_q == FETCH) && ((3'(count_q) + 3'(in_flight_q)) < 3'd3);
    last_pix = (col_q == COL_LAST) && (line_q == LINE_LAST);
    push     = in_flight_q;
    pop      = pix_valid && pix_ready;

    in_flight_d = issue;
    sof_fl_d    = (col_q == '0) && (line_q == '0);
    eol_fl_d    = (col_q == COL_LAST);

    if (push) begin
      fifo_data_d[wr_ptr_q] = mem_rd_data;
      fifo_sof_d[wr_ptr_q]  = sof_fl_q;
      fifo_eol_d[wr_ptr_q]  = eol_fl_q;
      wr_ptr_d = (wr_ptr_q == 2'd2) ? 2'd0 : wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == 2'd2) ? 2'd0 : rd_ptr_q + 2'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    if (issue) begin
      addr_d = addr_q + ADDR_WIDTH'(1);
      if (col_q == COL_LAST) begin
        col_d  = '0;
        line_d = line_q + LW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end

    case (state_q)
      IDLE: begin
        col_d  = '0;
        line_d = '0;
        addr_d = BASE_A;
        if (start) state_d = FETCH;
      end
      FETCH: if (issue && last_pix) state_d = DRAIN;
      DRAIN: if ((count_d == 2'd0) && !in_flight_q) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      col_q       <= '0;
      line_q      <= '0;
      addr_q      <= BASE_A;
      in_flight_q <= 1'b0;
      sof_fl_q    <= 1'b0;
      eol_fl_q    <= 1'b0;
      count_q     <= 2'd0;
      rd_ptr_q    <= 2'd0;
      wr_ptr_q    <= 2'd0;
      fifo_sof_q  <= '0;
      fifo_eol_q  <= '0;
      for (int i = 0; i < 3; i++) fifo_data_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      line_q      <= line_d;
      addr_q      <= addr_d;
      in_flight_q <= in_flight_d;
      sof_fl_q    <= sof_fl_d;
      eol_fl_q    <= eol_fl_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      fifo_sof_q  <= fifo_sof_d;
      fifo_eol_q  <= fifo_eol_d;
      fifo_data_q <= fifo_data_d;
    end
  end

endmodule
